exec_unit_pipe: RTL and testbench

Parametrised, handshaked execution stage for the pipelined processor. It sits between operand fetch/decode and memory/writeback. It generalises the fixed 64-bit single-cycle execute stage with configurable widths, a multi-cycle multiply with a busy state machine, valid/ready flow control, a subtract op, and a pipeline flush. Branch target and branch decision are produced alongside the ALU result and travel with it.

---
 rtl/exec_unit_pipe.sv | 196 +++++++++++++++++++
 tb/tb_exec_unit_pipe.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/exec_unit_pipe.sv
// exec_unit_pipe
// ---------------------------------------------------------------------------
// Handshaked execute stage. It sits between operand fetch/decode and
// memory/writeback, and it drives one registered output slot.
//   - Single-cycle ops load the output register on accept.
//   - A multiply takes MUL_CYCLES cycles. In that time a small FSM holds the
//     operands and keeps in_ready low.
//   - Branch target and branch decision are formed from the accepted inputs.
//     They are registered together with the ALU result.
//
// Ports
//   clk, rst_n          clock, synchronous active-low reset
//   in_valid/in_ready   upstream handshake (accept = in_valid && in_ready)
//   pc, ctrl_in, op1, op2, addr_in, rd_in, flag
//                       instruction fields
//                       ctrl_in[2:0] = opcode
//                       ctrl_in[3]   = conditional branch
//                       ctrl_in[7]   = jump
//   flush               kills in-flight work (a mul, or a pending result)
//   out_valid/out_ready downstream handshake
//   ctrl_out, result, addr_out, rd_out, branch_pc, branch_taken
//                       registered result fields
// ---------------------------------------------------------------------------
module exec_unit_pipe #(
    parameter int DATA_W     = 64,
    parameter int ADDR_W     = 8,
    parameter int REG_W      = 4,
    parameter int MUL_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] pc,
    input  logic [7:0]        ctrl_in,
    input  logic [DATA_W-1:0] op1,
    input  logic [DATA_W-1:0] op2,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic [REG_W-1:0]  rd_in,
    input  logic              flag,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [7:0]        ctrl_out,
    output logic [DATA_W-1:0] result,
    output logic [ADDR_W-1:0] addr_out,
    output logic [REG_W-1:0]  rd_out,
    output logic [ADDR_W-1:0] branch_pc,
    output logic              branch_taken
);

    localparam logic [2:0] OP_MUL = 3'b010;
    // Last value the counter reaches before the multiply result is loaded.
    localparam logic [3:0] CNT_LAST = 4'((MUL_CYCLES > 1) ? MUL_CYCLES - 2 : 0);

    typedef enum logic [0:0] {S_IDLE, S_MUL} state_e;

    // Fields that travel alongside the result.
    typedef struct packed {
        logic [7:0]        ctrl;
        logic [ADDR_W-1:0] addr;
        logic [REG_W-1:0]  rd;
        logic [ADDR_W-1:0] bpc;
        logic              bt;
    } side_t;

    function automatic logic [DATA_W-1:0] alu(input logic [2:0]        opc,
                                               input logic [DATA_W-1:0] a,
                                               input logic [DATA_W-1:0] b);
        case (opc)
            3'b001:  alu = a + b;
            3'b010:  alu = a * b;              // low DATA_W bits of the product
            3'b011:  alu = a + DATA_W'(1);
            3'b100:  alu = a ^ b;
            3'b101:  alu = a - b;
            3'b110:  alu = DATA_W'(a == b);
            default: alu = '0;
        endcase
    endfunction

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] result_q, result_d;
    side_t             side_q, side_d;
    side_t             pend_q, pend_d;       // side fields of the mul in flight
    logic [DATA_W-1:0] mul_a_q, mul_a_d;
    logic [DATA_W-1:0] mul_b_q, mul_b_d;

    side_t             in_side;
    logic              accept;
    logic              in_mul;
    logic [DATA_W-1:0] alu_res;

    assign in_ready = rst_n && !flush && (state_q == S_IDLE) &&
                      (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;
    assign in_mul   = (state_q == S_MUL);

    always_comb begin
        in_side.ctrl = ctrl_in;
        in_side.addr = addr_in;
        in_side.rd   = rd_in;
        in_side.bpc  = pc + addr_in;
        in_side.bt   = (ctrl_in[3] & flag) | ctrl_in[7];
    end

    // A single ALU serves both paths. While in S_MUL it multiplies the held
    // operands; otherwise it works on the live inputs.
    assign alu_res = in_mul ? alu(OP_MUL, mul_a_q, mul_b_q)
                            : alu(ctrl_in[2:0], op1, op2);

    always_comb begin
        // NOTE: every next-state signal gets a default first, so no path leaves one unassigned (which would infer a latch).
        state_d     = state_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        result_d    = result_q;
        side_d      = side_q;
        pend_d      = pend_q;
        mul_a_d     = mul_a_q;
        mul_b_d     = mul_b_q;

        if (flush) begin
            state_d     = S_IDLE;
            cnt_d       = '0;
            out_valid_d = 1'b0;
        end else begin
            if (out_valid_q && out_ready) begin
                out_valid_d = 1'b0;
            end
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        if (ctrl_in[2:0] == OP_MUL && MUL_CYCLES > 1) begin
                            state_d = S_MUL;
                            cnt_d   = '0;
                            pend_d  = in_side;
                            mul_a_d = op1;
                            mul_b_d = op2;
                        end else begin
                            out_valid_d = 1'b1;
                            result_d    = alu_res;
                            side_d      = in_side;
                        end
                    end
                end
                S_MUL: begin
                    if (cnt_q == CNT_LAST) begin
                        state_d     = S_IDLE;
                        cnt_d       = '0;
                        out_valid_d = 1'b1;
                        result_d    = alu_res;
                        side_d      = pend_q;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments, so all registers update together from the same pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            side_q      <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            side_q      <= side_d;
        end
    end

    // NOTE: the held mul operands are deliberately not reset. They are only read in S_MUL, which reset and flush both leave.
    always_ff @(posedge clk) begin
        pend_q  <= pend_d;
        mul_a_q <= mul_a_d;
        mul_b_q <= mul_b_d;
    end

    assign out_valid    = out_valid_q;
    assign result       = result_q;
    assign ctrl_out     = side_q.ctrl;
    assign addr_out     = side_q.addr;
    assign rd_out       = side_q.rd;
    assign branch_pc    = side_q.bpc;
    assign branch_taken = side_q.bt;

endmodule

// File: tb/tb_exec_unit_pipe.sv
// tb_exec_unit_pipe
// ---------------------------------------------------------------------------
// Directed bench for exec_unit_pipe with the default parameters
// (DATA_W=64, ADDR_W=8, REG_W=4, MUL_CYCLES=4).
// Expected values are worked out by hand for each step.
// ---------------------------------------------------------------------------
module tb_exec_unit_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  pc;
    logic [7:0]  ctrl_in;
    logic [63:0] op1, op2;
    logic [7:0]  addr_in;
    logic [3:0]  rd_in;
    logic        flag;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  ctrl_out;
    logic [63:0] result;
    logic [7:0]  addr_out;
    logic [3:0]  rd_out;
    logic [7:0]  branch_pc;
    logic        branch_taken;

    int n_cmp  = 0;
    int n_fail = 0;

    exec_unit_pipe #(
        .DATA_W(64), .ADDR_W(8), .REG_W(4), .MUL_CYCLES(4)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .pc(pc), .ctrl_in(ctrl_in), .op1(op1), .op2(op2),
        .addr_in(addr_in), .rd_in(rd_in), .flag(flag), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .ctrl_out(ctrl_out), .result(result), .addr_out(addr_out),
        .rd_out(rd_out), .branch_pc(branch_pc), .branch_taken(branch_taken)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit past the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [7:0] c, input logic [63:0] a,
                         input logic [63:0] b, input logic [7:0] p, input logic [7:0] ad,
                         input logic [3:0] r, input logic f);
        in_valid = v; ctrl_in = c; op1 = a; op2 = b;
        pc = p; addr_in = ad; rd_in = r; flag = f;
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
        drive(1'b0, 8'h00, 64'd0, 64'd0, 8'h00, 8'h00, 4'd0, 1'b0);

        // ---- reset ----
        tick(); tick();
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_result", result, 64'd0);
        check("rst_ctrl_out", 64'(ctrl_out), 64'd0);
        check("rst_addr_out", 64'(addr_out), 64'd0);
        check("rst_rd_out", 64'(rd_out), 64'd0);
        check("rst_branch_pc", 64'(branch_pc), 64'd0);
        check("rst_branch_taken", 64'(branch_taken), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        rst_n = 1'b1; #1;
        check("post_rst_in_ready", 64'(in_ready), 64'd1);

        // ---- add / xor / sub back-to-back ----
        drive(1'b1, 8'h01, 64'd5, 64'd3, 8'h00, 8'h00, 4'd1, 1'b0);
        tick();
        check("add_valid", 64'(out_valid), 64'd1);
        check("add_result", result, 64'd8);
        check("add_rd", 64'(rd_out), 64'd1);
        drive(1'b1, 8'h04, 64'd5, 64'd3, 8'h00, 8'h00, 4'd2, 1'b0);
        #1 check("b2b_in_ready", 64'(in_ready), 64'd1);
        tick();
        check("xor_valid", 64'(out_valid), 64'd1);
        check("xor_result", result, 64'd6);
        check("xor_rd", 64'(rd_out), 64'd2);
        drive(1'b1, 8'h05, 64'd5, 64'd3, 8'h00, 8'h00, 4'd3, 1'b0);
        tick();
        check("sub_result", result, 64'd2);
        drive(1'b1, 8'h05, 64'd0, 64'd1, 8'h00, 8'h00, 4'd4, 1'b0);
        tick();
        check("sub_wrap_result", result, 64'hFFFF_FFFF_FFFF_FFFF);
        check("sub_wrap_valid", 64'(out_valid), 64'd1);
        in_valid = 1'b0;
        tick();
        check("drain_valid", 64'(out_valid), 64'd0);

        // ---- multiply, 4 cycles ----
        drive(1'b1, 8'h02, 64'h1_0000_0000, 64'h1_0000_0001, 8'h00, 8'h00, 4'd5, 1'b0);
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("mul_busy_ready_%0d", i), 64'(in_ready), 64'd0);
            check($sformatf("mul_busy_valid_%0d", i), 64'(out_valid), 64'd0);
            tick();
        end
        check("mul_valid", 64'(out_valid), 64'd1);
        check("mul_result", result, 64'h1_0000_0000);
        check("mul_rd", 64'(rd_out), 64'd5);
        check("mul_done_ready", 64'(in_ready), 64'd1);
        tick();
        check("mul_drain_valid", 64'(out_valid), 64'd0);

        // ---- backpressure ----
        out_ready = 1'b0;
        drive(1'b1, 8'h01, 64'd10, 64'd20, 8'h00, 8'h00, 4'd2, 1'b0);
        tick();
        drive(1'b1, 8'h04, 64'hF0, 64'h0F, 8'h00, 8'h00, 4'd3, 1'b0);
        for (int i = 0; i < 5; i++) begin
            #1;
            check($sformatf("bp_valid_%0d", i), 64'(out_valid), 64'd1);
            check($sformatf("bp_result_%0d", i), result, 64'd30);
            check($sformatf("bp_rd_%0d", i), 64'(rd_out), 64'd2);
            check($sformatf("bp_ctrl_%0d", i), 64'(ctrl_out), 64'h01);
            check($sformatf("bp_in_ready_%0d", i), 64'(in_ready), 64'd0);
            tick();
        end
        out_ready = 1'b1;
        #1 check("bp_release_ready", 64'(in_ready), 64'd1);
        tick();
        check("bp_second_valid", 64'(out_valid), 64'd1);
        check("bp_second_result", result, 64'hFF);
        check("bp_second_rd", 64'(rd_out), 64'd3);
        in_valid = 1'b0;
        tick();
        check("bp_drain_valid", 64'(out_valid), 64'd0);

        // ---- branches ----
        drive(1'b1, 8'h09, 64'd1, 64'd1, 8'hF0, 8'h20, 4'd6, 1'b1);
        tick();
        check("br_cond_taken", 64'(branch_taken), 64'd1);
        check("br_cond_pc_wrap", 64'(branch_pc), 64'h10);
        check("br_cond_addr", 64'(addr_out), 64'h20);
        check("br_cond_ctrl", 64'(ctrl_out), 64'h09);
        check("br_cond_result", result, 64'd2);
        drive(1'b1, 8'h09, 64'd1, 64'd1, 8'hF0, 8'h20, 4'd6, 1'b0);
        tick();
        check("br_cond_not_taken", 64'(branch_taken), 64'd0);
        check("br_cond_nt_pc", 64'(branch_pc), 64'h10);
        drive(1'b1, 8'hC0, 64'd7, 64'd7, 8'h12, 8'h03, 4'd7, 1'b0);
        tick();
        check("br_jump_taken", 64'(branch_taken), 64'd1);
        check("br_jump_pc", 64'(branch_pc), 64'h15);
        check("br_jump_ctrl", 64'(ctrl_out), 64'hC0);
        check("br_jump_result", result, 64'd0);

        // ---- cmp, increment wrap, opcode 111 ----
        drive(1'b1, 8'h06, 64'hABCD, 64'hABCD, 8'h00, 8'h00, 4'd8, 1'b0);
        tick();
        check("cmp_eq", result, 64'd1);
        drive(1'b1, 8'h06, 64'hABCD, 64'hABCE, 8'h00, 8'h00, 4'd8, 1'b0);
        tick();
        check("cmp_ne", result, 64'd0);
        drive(1'b1, 8'h03, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 8'h00, 8'h00, 4'd8, 1'b0);
        tick();
        check("inc_wrap", result, 64'd0);
        drive(1'b1, 8'h03, 64'd41, 64'd0, 8'h00, 8'h00, 4'd8, 1'b0);
        tick();
        check("inc", result, 64'd42);
        drive(1'b1, 8'h07, 64'd41, 64'd1, 8'h00, 8'h00, 4'd8, 1'b0);
        tick();
        check("op111_zero", result, 64'd0);
        in_valid = 1'b0;
        tick();

        // ---- flush during multiply ----
        drive(1'b1, 8'h02, 64'd3, 64'd4, 8'h00, 8'h00, 4'd9, 1'b0);
        tick();
        drive(1'b0, 8'h00, 64'd0, 64'd0, 8'h00, 8'h00, 4'd0, 1'b0);
        tick();
        flush = 1'b1;
        drive(1'b1, 8'h01, 64'd1, 64'd1, 8'h00, 8'h00, 4'd10, 1'b0);
        #1 check("flush_in_ready", 64'(in_ready), 64'd0);
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        #1;
        check("flush_after_ready", 64'(in_ready), 64'd1);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("flush_no_valid_%0d", i), 64'(out_valid), 64'd0);
            tick();
        end

        // ---- reset during multiply ----
        drive(1'b1, 8'h89, 64'd7, 64'd8, 8'h01, 8'h02, 4'd9, 1'b1);
        tick();
        check("pre_rst_result", result, 64'd15);
        check("pre_rst_taken", 64'(branch_taken), 64'd1);
        drive(1'b1, 8'h02, 64'd3, 64'd4, 8'h00, 8'h00, 4'd9, 1'b0);
        tick();
        in_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        #1 check("mid_rst_in_ready", 64'(in_ready), 64'd0);
        tick();
        rst_n = 1'b1;
        check("mrst_valid", 64'(out_valid), 64'd0);
        check("mrst_result", result, 64'd0);
        check("mrst_ctrl", 64'(ctrl_out), 64'd0);
        check("mrst_addr", 64'(addr_out), 64'd0);
        check("mrst_rd", 64'(rd_out), 64'd0);
        check("mrst_bpc", 64'(branch_pc), 64'd0);
        check("mrst_taken", 64'(branch_taken), 64'd0);
        #1 check("mrst_in_ready", 64'(in_ready), 64'd1);
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("mrst_no_valid_%0d", i), 64'(out_valid), 64'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
